if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the ARM pipeline; the producer side of the IF/ID pipeline register.
- Owns the program counter and issues requests to a variable-latency instruction memory over a req/ready handshake.
- Presents {pc+4, instruction} to the IF/ID register every cycle.
- Honours the hazard unit's freeze and the EXE stage's branch redirect.
- Inserts NOP bubbles while memory is busy.

---
 rtl/if_fetch_unit.sv | 112 +++++++++++
 tb/tb_if_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks req/ready to instruction memory,
// and feeds {pc+4, instruction} to the IF/ID register with NOP bubbles while waiting.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        freeze_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_address_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instruction_o,
    output logic        fetch_valid_o,
    output logic        fetch_stall_o
);

    // state     | meaning
    // S_FETCH   | request outstanding at pc_q; data forwarded on ready
    // S_HOLD    | word captured under freeze; replayed from hold_q, no request
    // S_DISCARD | wrong-path request in flight; drain it, then jump to redirect_q
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redirect_q, redirect_d;
    logic [31:0] hold_q, hold_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            redirect_q <= 32'h0;
            hold_q     <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_d    = redirect_q;
        hold_d        = hold_q;
        imem_req_o    = 1'b0;
        fetch_valid_o = 1'b0;
        instruction_o = NOP_INSTR;

        unique case (state_q)
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    if (branch_taken_i) begin
                        pc_d = branch_address_i;
                    end else begin
                        fetch_valid_o = 1'b1;
                        instruction_o = imem_rdata_i;
                        if (freeze_i) begin
                            hold_d  = imem_rdata_i;
                            state_d = S_HOLD;
                        end else begin
                            pc_d = pc_q + 32'd4;
                        end
                    end
                end else if (branch_taken_i) begin
                    // The request cannot be withdrawn, so remember where to go once it drains.
                    redirect_d = branch_address_i;
                    state_d    = S_DISCARD;
                end
            end
            S_HOLD: begin
                fetch_valid_o = 1'b1;
                instruction_o = hold_q;
                if (branch_taken_i) begin
                    pc_d    = branch_address_i;
                    state_d = S_FETCH;
                end else if (!freeze_i) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_FETCH;
                end
            end
            S_DISCARD: begin
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    pc_d    = branch_taken_i ? branch_address_i : redirect_q;
                    state_d = S_FETCH;
                end else if (branch_taken_i) begin
                    redirect_d = branch_address_i;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q + 32'd4;
    assign fetch_stall_o = ~fetch_valid_o;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: vector table, directed multi-cycle corners, and
// randomized traffic against a rule-level reference model with a latency memory.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        freeze_i;
    logic        branch_taken_i;
    logic [31:0] branch_address_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] instruction_o;
    logic        fetch_valid_o;
    logic        fetch_stall_o;

    if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .freeze_i         (freeze_i),
        .branch_taken_i   (branch_taken_i),
        .branch_address_i (branch_address_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_ready_i     (imem_ready_i),
        .imem_rdata_i     (imem_rdata_i),
        .pc_o             (pc_o),
        .instruction_o    (instruction_o),
        .fetch_valid_o    (fetch_valid_o),
        .fetch_stall_o    (fetch_stall_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        fr;
        logic        br;
        logic [31:0] ba;
        logic        rdy;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic        e_val;
        logic [31:0] e_ins;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hE000_0000;
    endfunction

    function automatic vec_t mk(input logic fr, input logic br, input logic [31:0] ba,
                                input logic rdy, input logic [31:0] rd,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic [31:0] e_pc, input logic e_val,
                                input logic [31:0] e_ins);
        vec_t v;
        v.fr = fr; v.br = br; v.ba = ba; v.rdy = rdy; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_val = e_val; v.e_ins = e_ins;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string nm, input logic e_req, input logic [31:0] e_addr,
                              input logic [31:0] e_pc, input logic e_val, input logic [31:0] e_ins);
        chk({nm, ".req"},   {31'd0, imem_req_o},    {31'd0, e_req});
        chk({nm, ".addr"},  imem_addr_o,            e_addr);
        chk({nm, ".pc"},    pc_o,                   e_pc);
        chk({nm, ".valid"}, {31'd0, fetch_valid_o}, {31'd0, e_val});
        chk({nm, ".stall"}, {31'd0, fetch_stall_o}, {31'd0, ~e_val});
        chk({nm, ".instr"}, instruction_o,          e_ins);
    endtask

    // Drive at the falling edge, compare just after, let the rising edge commit.
    task automatic step(input string nm, input vec_t v);
        @(negedge clk_i);
        freeze_i         = v.fr;
        branch_taken_i   = v.br;
        branch_address_i = v.ba;
        imem_ready_i     = v.rdy;
        imem_rdata_i     = v.rd;
        #1;
        check_outs(nm, v.e_req, v.e_addr, v.e_pc, v.e_val, v.e_ins);
    endtask

    task automatic do_reset();
        rst_i            = 1'b1;
        freeze_i         = 1'b0;
        branch_taken_i   = 1'b0;
        branch_address_i = 32'h0;
        imem_ready_i     = 1'b0;
        imem_rdata_i     = 32'h0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check_outs("reset", 1'b1, RESET_PC, RESET_PC + 32'd4, 1'b0, NOP);
        rst_i = 1'b0;
    endtask

    // Reference model state: fetch address, a frozen word being replayed,
    // and whether the request in flight belongs to an abandoned path.
    logic [31:0] m_pc, m_hold_word, m_target;
    logic        m_held, m_killed;
    logic        e_req, e_val;
    logic [31:0] e_ins;
    logic        mem_busy;
    int          wait_left;
    logic [31:0] mem_addr;
    logic        fr, br, rdy;
    logic [31:0] ba, rd;

    vec_t tbl[11];

    initial begin
        tbl[0]  = mk(0, 0, 32'h0,  1, word(32'h0),  1, 32'h0,  32'h4,  1, word(32'h0));
        tbl[1]  = mk(0, 0, 32'h0,  1, word(32'h4),  1, 32'h4,  32'h8,  1, word(32'h4));
        tbl[2]  = mk(1, 0, 32'h0,  1, word(32'h8),  1, 32'h8,  32'hC,  1, word(32'h8));
        tbl[3]  = mk(1, 0, 32'h0,  0, 32'hDEAD0000, 0, 32'h8,  32'hC,  1, word(32'h8));
        tbl[4]  = mk(1, 0, 32'h0,  0, 32'hDEAD0001, 0, 32'h8,  32'hC,  1, word(32'h8));
        tbl[5]  = mk(1, 0, 32'h0,  0, 32'hDEAD0002, 0, 32'h8,  32'hC,  1, word(32'h8));
        tbl[6]  = mk(0, 0, 32'h0,  0, 32'hDEAD0003, 0, 32'h8,  32'hC,  1, word(32'h8));
        tbl[7]  = mk(1, 0, 32'h0,  1, word(32'hC),  1, 32'hC,  32'h10, 1, word(32'hC));
        tbl[8]  = mk(1, 1, 32'h40, 0, 32'hDEAD0004, 0, 32'hC,  32'h10, 1, word(32'hC));
        tbl[9]  = mk(0, 0, 32'h0,  0, 32'hDEAD0005, 1, 32'h40, 32'h44, 0, NOP);
        tbl[10] = mk(0, 0, 32'h0,  1, word(32'h40), 1, 32'h40, 32'h44, 1, word(32'h40));

        do_reset();
        for (int i = 0; i < 11; i++) step($sformatf("tbl%0d", i), tbl[i]);

        // Three-cycle memory latency on the very first fetch.
        do_reset();
        for (int i = 0; i < 3; i++)
            step($sformatf("lat%0d", i), mk(0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 32'h4, 0, NOP));
        step("lat3", mk(0, 0, 32'h0, 1, word(32'h0), 1, 32'h0, 32'h4, 1, word(32'h0)));
        step("lat4", mk(0, 0, 32'h0, 0, 32'h0,       1, 32'h4, 32'h8, 0, NOP));

        // Two redirects while a slow fetch at 0x10 is in flight; the later one wins.
        do_reset();
        step("br0", mk(0, 1, 32'h10,  1, word(32'h0), 1, 32'h0,  32'h4,  0, NOP));
        step("br1", mk(0, 1, 32'h100, 0, 32'h0,       1, 32'h10, 32'h14, 0, NOP));
        step("br2", mk(0, 1, 32'h200, 0, 32'h0,       1, 32'h10, 32'h14, 0, NOP));
        step("br3", mk(1, 0, 32'h0,   0, 32'h0,       1, 32'h10, 32'h14, 0, NOP));
        step("br4", mk(1, 0, 32'h0,   1, word(32'h10),1, 32'h10, 32'h14, 0, NOP));
        step("br5", mk(0, 0, 32'h0,   0, 32'h0,       1, 32'h200, 32'h204, 0, NOP));

        // Async reset while draining a wrong-path request.
        step("rd0", mk(0, 1, 32'h300, 0, 32'h0, 1, 32'h200, 32'h204, 0, NOP));
        step("rd1", mk(0, 0, 32'h0,   0, 32'h0, 1, 32'h200, 32'h204, 0, NOP));
        #2 rst_i = 1'b1;
        #1 check_outs("rst_mid", 1'b1, RESET_PC, RESET_PC + 32'd4, 1'b0, NOP);
        @(negedge clk_i);
        rst_i = 1'b0;
        step("rd2", mk(0, 0, 32'h0, 1, word(32'h0), 1, RESET_PC, RESET_PC + 32'd4, 1, word(32'h0)));

        // PC wrap at the top of the address space.
        step("wr0", mk(0, 1, 32'hFFFF_FFFC, 1, 32'h0, 1, 32'h4, 32'h8, 0, NOP));
        step("wr1", mk(0, 0, 32'h0, 1, word(32'hFFFF_FFFC), 1, 32'hFFFF_FFFC, 32'h0, 1, word(32'hFFFF_FFFC)));
        step("wr2", mk(0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 32'h4, 0, NOP));

        // Randomized traffic against the reference model.
        do_reset();
        m_pc = RESET_PC; m_held = 1'b0; m_killed = 1'b0;
        m_hold_word = 32'h0; m_target = 32'h0;
        mem_busy = 1'b0; wait_left = 0; mem_addr = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            fr = ($urandom_range(3) == 0);
            br = ($urandom_range(7) == 0);
            ba = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFC);
            if (imem_req_o && !mem_busy) begin
                mem_busy  = 1'b1;
                wait_left = $urandom_range(3);
                mem_addr  = imem_addr_o;
            end
            rdy = mem_busy && (wait_left == 0);
            rd  = rdy ? word(mem_addr) : $urandom;
            freeze_i = fr; branch_taken_i = br; branch_address_i = ba;
            imem_ready_i = rdy; imem_rdata_i = rd;
            #1;

            e_req = !m_held;
            if (m_held) begin
                e_val = 1'b1; e_ins = m_hold_word;
            end else if (rdy && !m_killed && !br) begin
                e_val = 1'b1; e_ins = rd;
            end else begin
                e_val = 1'b0; e_ins = NOP;
            end
            check_outs($sformatf("rnd%0d", c), e_req, m_pc, m_pc + 32'd4, e_val, e_ins);
            if (mem_busy) chk($sformatf("rnd%0d.addr_stable", c), imem_addr_o, mem_addr);

            if (br) begin
                if (m_held) begin
                    m_held = 1'b0; m_pc = ba;
                end else if (rdy) begin
                    m_pc = ba; m_killed = 1'b0;
                end else begin
                    m_killed = 1'b1; m_target = ba;
                end
            end else if (m_held) begin
                if (!fr) begin
                    m_held = 1'b0; m_pc = m_pc + 32'd4;
                end
            end else if (rdy) begin
                if (m_killed) begin
                    m_pc = m_target; m_killed = 1'b0;
                end else if (fr) begin
                    m_held = 1'b1; m_hold_word = rd;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end

            if (rdy) mem_busy = 1'b0;
            else if (mem_busy) wait_left--;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
